// File: rtl/m_decode_queue.sv
// Buffered multi-lane instruction kind decoder: classifies each lane at enqueue and
// holds {instr, kinds, mask} bundles in a DEPTH-entry FIFO towards the issue stage.

package m_decode_queue_pkg;
    typedef enum logic [2:0] {
        KIND_INVALID = 3'd0,
        KIND_RRR     = 3'd1,
        KIND_MEMORY  = 3'd2,
        KIND_MODEL   = 3'd3,
        KIND_RRI     = 3'd4,
        KIND_CUSTOM  = 3'd5
    } e_kind;
endpackage

module m_decode_queue
    import m_decode_queue_pkg::*;
#(
    parameter int LANES     = 2,
    parameter int DEPTH     = 4,
    parameter int CUSTOM_EN = 1,
    parameter int CNT_W     = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [32*LANES-1:0]        in_instr,
    input  logic [LANES-1:0]           in_mask,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [32*LANES-1:0]        out_instr,
    output e_kind [LANES-1:0]          out_kind,
    output logic [LANES-1:0]           out_mask,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic [CNT_W-1:0]           illegal_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [32*LANES-1:0] mem_instr [DEPTH];
    e_kind [LANES-1:0]   mem_kind  [DEPTH];
    logic [LANES-1:0]    mem_mask  [DEPTH];

    logic [AW-1:0]     wptr, rptr;
    logic              push, pop;
    e_kind [LANES-1:0] in_kind;
    logic [CNT_W:0]    inc, cnt_sum;

    function automatic e_kind decode(input logic [3:0] op, input logic lane_on);
        e_kind k;
        if (!lane_on) begin
            k = KIND_INVALID;
        end else begin
            case (op)
                4'h0:                   k = KIND_RRR;
                4'h1:                   k = KIND_MEMORY;
                4'h2:                   k = KIND_MODEL;
                4'h4, 4'h5, 4'h6, 4'h7: k = KIND_RRI;
                4'hC, 4'hD, 4'hE, 4'hF: k = (CUSTOM_EN != 0) ? KIND_CUSTOM : KIND_INVALID;
                default:                k = KIND_INVALID;
            endcase
        end
        return k;
    endfunction

    assign in_ready  = (level != LW'(DEPTH));
    assign out_valid = (level != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        inc = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            in_kind[i] = decode(in_instr[32*i+28 +: 4], in_mask[i]);
            if (in_mask[i] && in_kind[i] == KIND_INVALID)
                inc = inc + {{CNT_W{1'b0}}, 1'b1};
        end
        cnt_sum = {1'b0, illegal_count} + inc;
    end

    // Storage has no reset; out_* are masked while empty so stale contents never leak.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_instr[wptr] <= in_instr;
            mem_kind[wptr]  <= in_kind;
            mem_mask[wptr]  <= in_mask;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr          <= '0;
            rptr          <= '0;
            level         <= '0;
            illegal_count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            if (push)
                illegal_count <= cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
        end
    end

    always_comb begin
        out_instr = out_valid ? mem_instr[rptr] : '0;
        out_mask  = out_valid ? mem_mask[rptr]  : '0;
        for (int unsigned i = 0; i < LANES; i++)
            out_kind[i] = out_valid ? mem_kind[rptr][i] : KIND_INVALID;
    end

endmodule

// File: tb/tb_m_decode_queue.sv
// Self-checking bench for m_decode_queue: vector table, directed corner sequences and
// random traffic against a queue-based reference model.

module tb_m_decode_queue;
    import m_decode_queue_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, flush, in_valid, out_ready;
    logic [63:0] in_instr;
    logic [1:0]  in_mask;
    logic        in_ready, out_valid;
    logic [63:0] out_instr;
    e_kind [1:0] out_kind;
    logic [1:0]  out_mask;
    logic [2:0]  level;
    logic [15:0] illegal_count;

    logic        b_flush, b_in_valid, b_out_ready;
    logic [63:0] b_in_instr;
    logic [1:0]  b_in_mask;
    logic        b_in_ready, b_out_valid;
    logic [63:0] b_out_instr;
    e_kind [1:0] b_out_kind;
    logic [1:0]  b_out_mask;
    logic [2:0]  b_level;
    logic [3:0]  b_illegal_count;

    m_decode_queue #(.LANES(2), .DEPTH(DEPTH), .CUSTOM_EN(1), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_mask(in_mask), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_kind(out_kind), .out_mask(out_mask), .level(level),
        .illegal_count(illegal_count));

    m_decode_queue #(.LANES(2), .DEPTH(DEPTH), .CUSTOM_EN(0), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_instr(b_in_instr), .in_mask(b_in_mask), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_instr(b_out_instr), .out_kind(b_out_kind), .out_mask(b_out_mask), .level(b_level),
        .illegal_count(b_illegal_count));

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [63:0] instr;
        logic [5:0]  kind;
        logic [1:0]  mask;
    } ent_t;

    ent_t q[$];
    int   ref_cnt = 0;

    typedef struct {
        logic [63:0] instr;
        logic [1:0]  mask;
        e_kind       k1;
        e_kind       k0;
        int          ill;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    function automatic e_kind ref_kind(input logic [31:0] w, input logic on, input bit custom);
        int op;
        op = int'(w >> 28);
        if (!on)           return KIND_INVALID;
        if (op >= 12)      return custom ? KIND_CUSTOM : KIND_INVALID;
        if (op >= 8)       return KIND_INVALID;
        if (op >= 4)       return KIND_RRI;
        if (op == 0)       return KIND_RRR;
        if (op == 1)       return KIND_MEMORY;
        if (op == 2)       return KIND_MODEL;
        return KIND_INVALID;
    endfunction

    // One clock: decide the handshakes from pre-edge inputs, then update the model.
    task automatic cycle();
        bit   do_push, do_pop;
        ent_t e;
        e_kind k1, k0;
        int   n;
        do_push = in_valid && (q.size() != DEPTH);
        do_pop  = out_ready && (q.size() != 0);
        k0 = ref_kind(in_instr[31:0], in_mask[0], 1'b1);
        k1 = ref_kind(in_instr[63:32], in_mask[1], 1'b1);
        @(posedge clk);
        #1;
        if (flush) begin
            q.delete();
        end else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                e.instr = in_instr;
                e.kind  = {k1, k0};
                e.mask  = in_mask;
                q.push_back(e);
                n = 0;
                if (in_mask[0] && k0 == KIND_INVALID) n++;
                if (in_mask[1] && k1 == KIND_INVALID) n++;
                ref_cnt = (ref_cnt + n > 65535) ? 65535 : ref_cnt + n;
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".out_valid"}, 64'(out_valid), 64'(q.size() != 0));
        check({tag, ".in_ready"}, 64'(in_ready), 64'(q.size() != DEPTH));
        check({tag, ".level"}, 64'(level), 64'(q.size()));
        check({tag, ".illegal"}, 64'(illegal_count), 64'(ref_cnt));
        if (q.size() != 0) begin
            check({tag, ".instr"}, out_instr, q[0].instr);
            check({tag, ".kind"}, 64'(out_kind), 64'(q[0].kind));
            check({tag, ".mask"}, 64'(out_mask), 64'(q[0].mask));
        end else begin
            check({tag, ".kind_empty"}, 64'(out_kind), 64'({KIND_INVALID, KIND_INVALID}));
            check({tag, ".mask_empty"}, 64'(out_mask), 64'd0);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    initial begin
        vecs[0] = '{64'h4000_0000_1000_0000, 2'b11, KIND_RRI,     KIND_MEMORY, 0};
        vecs[1] = '{64'h3fff_ffff_8000_0000, 2'b11, KIND_INVALID, KIND_INVALID, 2};
        vecs[2] = '{64'hbfff_ffff_0000_0000, 2'b01, KIND_INVALID, KIND_RRR,    0};
        vecs[3] = '{64'hc000_0000_2000_0000, 2'b11, KIND_CUSTOM,  KIND_MODEL,  0};
        vecs[4] = '{64'h7fff_ffff_b000_0000, 2'b10, KIND_RRI,     KIND_INVALID, 0};
        vecs[5] = '{64'hf123_4567_5000_0000, 2'b11, KIND_CUSTOM,  KIND_RRI,    0};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_mask = '0;
        b_flush = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_instr = '0; b_in_mask = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        check("reset.in_ready_b", 64'(b_in_ready), 64'd1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Vector table: push into an empty queue, inspect the head, then pop it.
        for (int i = 0; i < 6; i++) begin
            int prev;
            prev = int'(illegal_count);
            in_valid = 1'b1; in_instr = vecs[i].instr; in_mask = vecs[i].mask; out_ready = 1'b0;
            cycle();
            in_valid = 1'b0;
            check($sformatf("vec%0d.kind", i), 64'(out_kind), 64'({vecs[i].k1, vecs[i].k0}));
            check($sformatf("vec%0d.count", i), 64'(illegal_count), 64'(prev + vecs[i].ill));
            check($sformatf("vec%0d.level", i), 64'(level), 64'd1);
            check_all($sformatf("vec%0d", i));
            out_ready = 1'b1;
            cycle();
            out_ready = 1'b0;
            check_all($sformatf("vec%0d.pop", i));
        end

        // Fill to full; a fifth offer is ignored; one pop reopens in_ready next cycle.
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_instr = rnd64(); in_mask = 2'b11;
            cycle();
            check_all($sformatf("fill%0d", i));
        end
        check("full.level", 64'(level), 64'd4);
        check("full.in_ready", 64'(in_ready), 64'd0);
        in_valid = 1'b0; out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        check("afterpop.in_ready", 64'(in_ready), 64'd1);
        check_all("afterpop");
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check_all($sformatf("drain%0d", i));
        end
        out_ready = 1'b0;

        // Steady stream at level 2 across several pointer wraps.
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_instr = rnd64(); in_mask = 2'($urandom_range(0, 3));
            cycle();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_instr = rnd64(); in_mask = 2'($urandom_range(0, 3));
            cycle();
            check($sformatf("stream%0d.level", i), 64'(level), 64'd2);
            check_all($sformatf("stream%0d", i));
        end
        out_ready = 1'b0;
        in_instr = rnd64();
        cycle();
        check("preflush.level", 64'(level), 64'd3);

        // Flush beats a concurrent push carrying invalid lanes; the counter is retained.
        begin
            int keep;
            keep = int'(illegal_count);
            flush = 1'b1; in_valid = 1'b1; in_instr = 64'h9000_0000_3000_0000; in_mask = 2'b11;
            cycle();
            flush = 1'b0; in_valid = 1'b0;
            check("flush.level", 64'(level), 64'd0);
            check("flush.out_valid", 64'(out_valid), 64'd0);
            check("flush.count", 64'(illegal_count), 64'(keep));
            check_all("flush");
        end

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            flush     = ($urandom_range(0, 31) == 0);
            in_instr  = rnd64();
            in_mask   = 2'($urandom_range(0, 3));
            cycle();
            check_all($sformatf("rnd%0d", i));
        end
        flush = 1'b0;

        // Asynchronous reset mid-stream, observed before any clock edge.
        in_valid = 1'b1; out_ready = 1'b0; in_mask = 2'b11; in_instr = 64'h8000_0000_8000_0000;
        cycle();
        cycle();
        #1;
        rst_n = 1'b0;
        #1;
        q.delete();
        ref_cnt = 0;
        check("areset.out_valid", 64'(out_valid), 64'd0);
        check("areset.in_ready", 64'(in_ready), 64'd1);
        check_all("areset");
        #2;
        rst_n = 1'b1;
        in_valid = 1'b0;
        cycle();
        check_all("postreset");

        // CUSTOM_EN=0 and a 4-bit counter: custom opcodes count as invalid and saturate at 15.
        b_out_ready = 1'b1; b_in_valid = 1'b1;
        b_in_instr = 64'hffff_ffff_c000_0000; b_in_mask = 2'b11;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("sat%0d.count", k), 64'(b_illegal_count), 64'((2 * k > 15) ? 15 : 2 * k));
            check($sformatf("sat%0d.kind", k), 64'(b_out_kind), 64'({KIND_INVALID, KIND_INVALID}));
            check($sformatf("sat%0d.level", k), 64'(b_level), 64'd1);
        end
        b_in_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/m_decode_queue.md
Name: m_decode_queue

Overview:
- Parametrised, buffered successor to the single-instruction combinational kind decoder.
- Accepts a bundle of LANES instruction words per handshake and classifies each lane by instruction kind at enqueue.
- Stores the instruction words, decoded kinds and lane masks in a DEPTH-entry FIFO, which it presents to the issue stage via valid/ready.
- Sits between fetch and issue. Also keeps a saturating count of invalid instructions for debug.

Parameters:
- LANES, 2, instructions per bundle (1..4).
- DEPTH, 4, FIFO entries (power of two, >=2).
- CUSTOM_EN, 1, when 0 the custom opcode space (instr[31:30]==2'b11) decodes as KIND_INVALID.
- CNT_W, 16, width of the illegal-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous queue clear.
- in_valid  in  1  bundle offered.
- in_ready  out  1  queue can accept a bundle.
- in_instr  in  32*LANES  lane i at [32*i+31:32*i].
- in_mask  in  LANES  lane-valid bits.
- out_valid  out  1  head entry present.
- out_ready  in  1  issue consumes the head.
- out_instr  out  32*LANES  head instruction words.
- out_kind  out  e_kind x LANES  head decoded kinds, packed array of e_kind.
- out_mask  out  LANES  head lane-valid bits.
- level  out  $clog2(DEPTH+1)  occupied entries.
- illegal_count  out  CNT_W  saturating invalid counter.

Behaviour:
- Reset (rst_n low, asynchronous):
  - level=0, out_valid=0, in_ready=1, illegal_count=0, read and write pointers 0.
  - Storage contents are don't-care; out_mask is forced to 0 while empty.
- Decode table, per lane, on instr[31:28], fixed:
  - 0x0 -> KIND_RRR
  - 0x1 -> KIND_MEMORY
  - 0x2 -> KIND_MODEL
  - 0x3 -> KIND_INVALID
  - 0x4..0x7 -> KIND_RRI
  - 0x8..0xB -> KIND_INVALID
  - 0xC..0xF -> KIND_CUSTOM if CUSTOM_EN, else KIND_INVALID
  - A lane with in_mask[i]=0 stores KIND_INVALID regardless of instr.
- Push: in_valid && in_ready at a rising edge writes {instr, kinds, mask} at the write pointer. The pointer wraps modulo DEPTH.
- Pop: out_valid && out_ready advances the read pointer, also wrapping modulo DEPTH.
- in_ready = (level != DEPTH). Registered-only; no combinational path from out_ready.
- out_valid = (level != 0). out_instr, out_kind and out_mask are driven from the head entry. While out_valid=0, out_kind = KIND_INVALID on all lanes and out_mask=0.
- Latency: a bundle pushed at edge N is visible at out_* after edge N (one cycle). There is no fall-through.
- Simultaneous push and pop with 0<level<DEPTH: level is unchanged and both pointers advance.
- Empty: pop is impossible (out_valid=0). Full: push is impossible (in_ready=0); a pop at full frees one slot, visible as in_ready=1 the next cycle.
- FIFO order is strict; lane order within a bundle is preserved.
- flush=1 at an edge: level and both pointers return to 0.
  - flush takes priority over a push or pop in the same cycle; that push is dropped and not counted.
  - illegal_count is NOT cleared by flush.
- illegal_count: on each accepted push it adds the number of lanes with in_mask[i]=1 and decoded kind KIND_INVALID.
  - It saturates at all-ones and never wraps.
  - An increment that would overflow clamps to the maximum.
- Reset asserted mid-operation: the queue empties immediately (asynchronously); handshake outputs return to their reset values within the same cycle.

Test Plan:
- Reset, then push one bundle with LANES=2: in_instr={32'h4000_0000, 32'h1000_0000}, mask=2'b11.
  - Next cycle: out_valid=1, out_kind={KIND_RRI, KIND_MEMORY}, level=1, illegal_count=0.
- out_ready=0, push 4 bundles:
  - After the 4th, level=4 and in_ready=0; a 5th in_valid is ignored.
  - Pop one: in_ready=1 next cycle; the head is the 1st bundle.
- Push lanes {32'h3fff_ffff, 32'h8000_0000}, mask=2'b11 -> illegal_count +=2.
  - Push {32'hbfff_ffff, 32'h0000_0000} with mask=2'b01 -> kinds {INVALID, RRR}, illegal_count unchanged.
- CUSTOM_EN=1: 32'hc000_0000 -> KIND_CUSTOM. CUSTOM_EN=0: 32'hffff_ffff -> KIND_INVALID, counter increments.
- Steady stream with in_valid=out_ready=1 for 20 cycles at level=2:
  - level stays 2, one bundle per cycle, order preserved across pointer wrap.
- flush together with in_valid at level=3:
  - next cycle level=0, out_valid=0, the pushed bundle is absent, illegal_count retained.
- Preload illegal_count to max-1, push two invalid lanes -> saturates at max.
- Drop rst_n mid-stream -> out_valid=0 and in_ready=1 without waiting for a clock edge.
